to_serial_padded: RTL and testbench
===================================

Name: to_serial_padded

Overview:
- Parallel-to-digit-serial converter for the inter-layer path (bn_relu output -> windower_serial).
- Splits NO_CH words of BW_IN bits into BW_OUT-bit digits over a programmable slot count SER_CYC.
- Slots beyond the real digits are padded, and an act_out qualifier marks the real digits. This replaces ad-hoc per-layer counter gating when a layer's serial period exceeds its digit count.
- Adds a small input FIFO with sticky overflow reporting.

Parameters:
- NO_CH, 64, number of channels.
- BW_IN, 16, bits per channel input word.
- BW_OUT, 1, bits per channel per serial digit; BW_IN % BW_OUT == 0.
- SER_CYC, 16, serial slots per word; power of 2; SER_CYC >= NDIG, where NDIG = BW_IN/BW_OUT.
- LSB_FIRST, 1, 1 = least-significant digit first, 0 = most-significant first.
- PAD_MODE, 0, 0 = pad slots are zero, 1 = pad slots are sign-extension of the channel MSB.
- BUF_DEPTH, 2, input FIFO depth in words; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- vld_in  in  1  data_in valid, one word per asserted cycle
- data_in  in  NO_CH*BW_IN  channel i at [i*BW_IN +: BW_IN]
- vld_out  out  1  high on every slot (real and pad) of a word being serialised
- data_out  out  NO_CH*BW_OUT  channel i digit at [i*BW_OUT +: BW_OUT]
- act_out  out  1  vld_out and slot index < NDIG (real digit); downstream conv valid
- sow  out  1  high on slot 0 of each word (serial reset for downstream)
- busy  out  1  serialiser active or FIFO non-empty
- ovf  out  1  sticky: a word was dropped because storage was full

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - vld_out, act_out, sow, busy, ovf, data_out all 0.
  - FIFO emptied; slot counter 0.
  - rst mid-word aborts the word; no further slots are emitted.
- Storage: one shift register (word in service) plus a FIFO of BUF_DEPTH words.
- Slot counter: log2(SER_CYC) bits; counts 0..SER_CYC-1 while serialising, then wraps.
- Load condition: serialiser idle, or at slot SER_CYC-1 (last slot).
- Load source when the load condition holds:
  - FIFO non-empty: pop the FIFO head.
  - FIFO empty and vld_in high: bypass data_in straight into the shift register.
  - Otherwise: go idle after the last slot.
- Otherwise, vld_in pushes to the FIFO.
- Latency: vld_in at cycle t, idle and FIFO empty -> slot 0 (sow=1) visible at t+1.
- Back-to-back words: the slot 0 of the next word follows the slot SER_CYC-1 of the current word with no gap.
- Digit k (k < NDIG) for channel i:
  - LSB_FIRST=1: word_i[k*BW_OUT +: BW_OUT].
  - LSB_FIRST=0: word_i[(NDIG-1-k)*BW_OUT +: BW_OUT].
- Slots NDIG..SER_CYC-1:
  - data_out = 0 when PAD_MODE=0, or all copies of word_i[BW_IN-1] when PAD_MODE=1.
  - vld_out=1, act_out=0.
- SER_CYC == NDIG: act_out == vld_out.
- Full condition: FIFO holds BUF_DEPTH words, shift register busy, and no pop this cycle.
  - vld_in while full -> word discarded, ovf set and held until rst.
  - Simultaneous pop and push while full: the push is accepted; no overflow.
- Sustained input must be ≤ 1 word per SER_CYC cycles. Bursts up to 1+BUF_DEPTH words are lossless.
- busy falls on the cycle after the last slot of the final word.
- Implementation: registered outputs only; no combinational path from vld_in to any output.

Test Plan:
Config NO_CH=2, BW_IN=8, BW_OUT=2, SER_CYC=8 (NDIG=4), BUF_DEPTH=2.
- Single word, LSB_FIRST=1, PAD_MODE=0: ch0=0xB4, ch1=0x81 at t=0 -> t=1..8 vld_out=1, sow only at t=1; ch0 digits 0,1,3,2,0,0,0,0; ch1 digits 1,0,0,2,0,0,0,0; act_out=1 at t=1..4 only; busy low at t=9.
- PAD_MODE=1 with the same data -> pad slots t=5..8 give ch0=3, ch1=3; LSB_FIRST=0 -> ch0 real digits 2,3,1,0.
- Burst of 4 words on consecutive cycles t=0..3 -> words 0-2 emitted contiguously over t=1..24 with sow at t=1, 9, 17; word 3 dropped; ovf=1 from t=4 onward.
- Push coincident with pop at full (word at t=8 while full) -> accepted, ovf stays 0, its slot 0 lands at t=25.
- rst asserted at slot 3 of a word -> next cycle all outputs 0, FIFO empty, ovf cleared; a new word at rst-deassert+1 starts at slot 0 one cycle later.
- SER_CYC=4 (== NDIG) with a stream of 1 word every 4 cycles -> continuous vld_out=act_out=1, no drops, ovf=0.

Source files
------------

// File: rtl/to_serial_padded.sv
// to_serial_padded: parallel-to-digit-serial converter with padded slots
// and a small input FIFO with sticky overflow reporting.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   vld_in    data_in valid, one word per asserted cycle
//   data_in   NO_CH words, channel i at [i*BW_IN +: BW_IN]
//   vld_out   high on every slot (real and pad) of a word in service
//   data_out  NO_CH digits, channel i at [i*BW_OUT +: BW_OUT]
//   act_out   vld_out and slot < NDIG (real digit)
//   sow       high on slot 0 of each word
//   busy      serialiser active or FIFO non-empty
//   ovf       sticky: a word was dropped because storage was full
module to_serial_padded #(
   parameter int NO_CH     = 64,
   parameter int BW_IN     = 16,
   parameter int BW_OUT    = 1,
   parameter int SER_CYC   = 16,
   parameter int LSB_FIRST = 1,
   parameter int PAD_MODE  = 0,
   parameter int BUF_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    vld_in,
   input  logic [NO_CH*BW_IN-1:0]  data_in,
   output logic                    vld_out,
   output logic [NO_CH*BW_OUT-1:0] data_out,
   output logic                    act_out,
   output logic                    sow,
   output logic                    busy,
   output logic                    ovf
);

   localparam int NDIG = BW_IN / BW_OUT;
   localparam int CW   = (SER_CYC > 1) ? $clog2(SER_CYC) : 1;
   localparam int PW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int NW   = $clog2(BUF_DEPTH + 1);
   localparam int WW   = NO_CH * BW_IN;
   localparam int DW   = NO_CH * BW_OUT;

   localparam logic [CW-1:0] SL_LAST = CW'(SER_CYC - 1);
   localparam logic [NW-1:0] CN_FULL = NW'(BUF_DEPTH);

   // Digit presented first from a word image, per channel.
   function automatic logic [DW-1:0] head(input logic [WW-1:0] w);
      logic [DW-1:0]    r;
      logic [BW_IN-1:0] ch;
      r = '0;
      for (int i = 0; i < NO_CH; i++) begin
         ch = w[i*BW_IN +: BW_IN];
         if (LSB_FIRST != 0)
            r[i*BW_OUT +: BW_OUT] = ch[BW_OUT-1:0];
         else
            r[i*BW_OUT +: BW_OUT] = ch[BW_IN-1 -: BW_OUT];
      end
      return r;
   endfunction

   // Channel sign bits of a word.
   function automatic logic [NO_CH-1:0] msbs(input logic [WW-1:0] w);
      logic [NO_CH-1:0] r;
      for (int i = 0; i < NO_CH; i++)
         r[i] = w[i*BW_IN + BW_IN - 1];
      return r;
   endfunction

   // Advance every channel by one digit. The vacated digit is filled
   // with the pad value, so after NDIG shifts the head digit is
   // automatically the pad and no separate pad mux is needed.
   function automatic logic [WW-1:0] step(
      input logic [WW-1:0]    w,
      input logic [NO_CH-1:0] s
   );
      logic [WW-1:0]     r;
      logic [BW_OUT-1:0] fill;
      logic [BW_OUT-1:0] d;
      r = '0;
      for (int i = 0; i < NO_CH; i++) begin
         fill = (PAD_MODE != 0) ? {BW_OUT{s[i]}} : '0;
         for (int dg = 0; dg < NDIG; dg++) begin
            if (LSB_FIRST != 0)
               d = (dg == NDIG - 1) ? fill :
                   w[i*BW_IN + ((dg + 1) % NDIG)*BW_OUT +: BW_OUT];
            else
               d = (dg == 0) ? fill :
                   w[i*BW_IN + ((dg + NDIG - 1) % NDIG)*BW_OUT +: BW_OUT];
            r[i*BW_IN + dg*BW_OUT +: BW_OUT] = d;
         end
      end
      return r;
   endfunction

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (32'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   logic [WW-1:0]    mem [BUF_DEPTH];
   logic [PW-1:0]    rd;
   logic [PW-1:0]    wr;
   logic [NW-1:0]    cnt;
   logic [NW-1:0]    cnt_nxt;
   logic [WW-1:0]    sr;
   logic [NO_CH-1:0] sgn;
   logic [CW-1:0]    slot;

   logic          last;
   logic          ld_ok;
   logic          fifo_ne;
   logic          pop;
   logic          byp;
   logic          full;
   logic          push;
   logic          drop;
   logic          load;
   logic          adv;
   logic [WW-1:0] ld_word;

   // vld_out doubles as the "serialiser active" state bit.
   always_comb begin
      last    = vld_out && (slot == SL_LAST);
      ld_ok   = !vld_out || last;
      fifo_ne = (cnt != '0);
      pop     = ld_ok && fifo_ne;
      byp     = ld_ok && !fifo_ne && vld_in;
      full    = (cnt == CN_FULL) && vld_out && !pop;
      push    = vld_in && !byp && !full;
      drop    = vld_in && full;
      load    = pop || byp;
      adv     = vld_out && !last;
      ld_word = pop ? mem[rd] : data_in;
      cnt_nxt = cnt;
      if (push && !pop)
         cnt_nxt = cnt + 1'b1;
      else if (pop && !push)
         cnt_nxt = cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_out  <= 1'b0;
         act_out  <= 1'b0;
         sow      <= 1'b0;
         busy     <= 1'b0;
         ovf      <= 1'b0;
         data_out <= '0;
         slot     <= '0;
         sr       <= '0;
         sgn      <= '0;
         cnt      <= '0;
         rd       <= '0;
         wr       <= '0;
      end else begin
         unique case (1'b1)
            load: begin
               vld_out  <= 1'b1;
               sow      <= 1'b1;
               act_out  <= 1'b1;
               slot     <= '0;
               data_out <= head(ld_word);
               sr       <= step(ld_word, msbs(ld_word));
               sgn      <= msbs(ld_word);
            end
            adv: begin
               sow      <= 1'b0;
               slot     <= slot + 1'b1;
               act_out  <= (32'(slot) + 32'd1) < 32'(NDIG);
               data_out <= head(sr);
               sr       <= step(sr, sgn);
            end
            default: begin
               vld_out  <= 1'b0;
               sow      <= 1'b0;
               act_out  <= 1'b0;
               data_out <= '0;
               slot     <= '0;
            end
         endcase
         busy <= load || adv || (cnt_nxt != '0);
         ovf  <= ovf || drop;
         cnt  <= cnt_nxt;
         if (pop)
            rd <= inc(rd);
         if (push)
            wr <= inc(wr);
      end
   end

endmodule

// File: tb/tb_to_serial_padded.sv
// tb_to_serial_padded: bench for to_serial_padded, four configurations
// driven in parallel and compared against a queue-based reference model.
module tb_to_serial_padded;

   localparam int NC = 4;
   localparam int SERS [NC] = '{8, 8, 8, 4};
   localparam int LSBS [NC] = '{1, 1, 0, 1};
   localparam int PADS [NC] = '{0, 1, 0, 0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vld_in = 1'b0;
   logic [15:0] data_in = '0;

   logic       vo [NC];
   logic       ao [NC];
   logic       so [NC];
   logic       bo [NC];
   logic       oo [NC];
   logic [3:0] dout [NC];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      to_serial_padded #(
         .NO_CH(2), .BW_IN(8), .BW_OUT(2),
         .SER_CYC(SERS[g]), .LSB_FIRST(LSBS[g]),
         .PAD_MODE(PADS[g]), .BUF_DEPTH(2)
      ) u_dut (
         .clk(clk), .rst(rst),
         .vld_in(vld_in), .data_in(data_in),
         .vld_out(vo[g]), .data_out(dout[g]),
         .act_out(ao[g]), .sow(so[g]),
         .busy(bo[g]), .ovf(oo[g])
      );
   end

   // Reference model: word in service, slot index, pending word queue.
   bit          m_act [NC];
   int          m_slot [NC];
   logic [15:0] m_word [NC];
   bit          m_ovf [NC];
   logic [15:0] mq [NC][$];

   int total = 0;
   int bad = 0;

   task automatic model_step(input bit v, input logic [15:0] d, input bit r);
      for (int c = 0; c < NC; c++) begin
         if (r) begin
            m_act[c] = 0;
            m_slot[c] = 0;
            m_ovf[c] = 0;
            mq[c].delete();
         end else if (!m_act[c] || m_slot[c] == SERS[c] - 1) begin
            if (mq[c].size() > 0) begin
               m_word[c] = mq[c].pop_front();
               m_act[c] = 1;
               m_slot[c] = 0;
               if (v) mq[c].push_back(d);
            end else if (v) begin
               m_word[c] = d;
               m_act[c] = 1;
               m_slot[c] = 0;
            end else begin
               m_act[c] = 0;
               m_slot[c] = 0;
            end
         end else begin
            m_slot[c]++;
            if (v) begin
               if (mq[c].size() < 2) mq[c].push_back(d);
               else m_ovf[c] = 1;
            end
         end
      end
   endtask

   function automatic logic [3:0] exp_dout(input int c);
      logic [3:0] r;
      int w;
      int k;
      int dg;
      r = '0;
      if (m_act[c]) begin
         for (int ch = 0; ch < 2; ch++) begin
            w = int'(m_word[c][ch*8 +: 8]);
            if (m_slot[c] < 4) begin
               k = (LSBS[c] != 0) ? m_slot[c] : 3 - m_slot[c];
               dg = (w >> (2 * k)) & 3;
            end else begin
               dg = (PADS[c] != 0 && w >= 128) ? 3 : 0;
            end
            r[ch*2 +: 2] = 2'(dg);
         end
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("vld_out c%0d", c), 32'(vo[c]), 32'(m_act[c]));
         chk($sformatf("sow c%0d", c), 32'(so[c]), 32'(m_act[c] && m_slot[c] == 0));
         chk($sformatf("act_out c%0d", c), 32'(ao[c]), 32'(m_act[c] && m_slot[c] < 4));
         chk($sformatf("data_out c%0d", c), 32'(dout[c]), 32'(exp_dout(c)));
         chk($sformatf("busy c%0d", c), 32'(bo[c]), 32'(m_act[c] || mq[c].size() > 0));
         chk($sformatf("ovf c%0d", c), 32'(oo[c]), 32'(m_ovf[c]));
      end
   endtask

   task automatic cyc(input bit v, input logic [15:0] d, input bit r);
      vld_in = v;
      data_in = d;
      rst = r;
      @(posedge clk);
      model_step(v, d, r);
      #1;
      check_all();
   endtask

   typedef struct {
      bit          v;
      logic [15:0] d;
      bit          ev;
      bit          es;
      bit          ea;
      bit          eb;
      logic [3:0]  da;
      logic [3:0]  db;
      logic [3:0]  dc;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int t;
      int rate;
      bit v;
      bit r;

      tbl[0] = '{1'b1, 16'h81B4, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 4'd4, 4'd10};
      tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 4'd3};
      tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 4'd1};
      tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd10, 4'd10, 4'd4};
      for (int i = 4; i < 8; i++)
         tbl[i] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, 4'd0};
      tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};

      // reset state
      cyc(1'b1, 16'hFFFF, 1'b1);
      cyc(1'b0, 16'h0000, 1'b1);
      for (int c = 0; c < NC; c++) begin
         chk("reset vld", 32'(vo[c]), 0);
         chk("reset busy", 32'(bo[c]), 0);
         chk("reset data", 32'(dout[c]), 0);
      end
      cyc(1'b0, 16'h0000, 1'b0);

      // single word, table driven
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].v, tbl[i].d, 1'b0);
         chk($sformatf("tbl%0d vld", i), 32'(vo[0]), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d sow", i), 32'(so[0]), 32'(tbl[i].es));
         chk($sformatf("tbl%0d act", i), 32'(ao[0]), 32'(tbl[i].ea));
         chk($sformatf("tbl%0d busy", i), 32'(bo[0]), 32'(tbl[i].eb));
         chk($sformatf("tbl%0d dA", i), 32'(dout[0]), 32'(tbl[i].da));
         chk($sformatf("tbl%0d dB", i), 32'(dout[1]), 32'(tbl[i].db));
         chk($sformatf("tbl%0d dC", i), 32'(dout[2]), 32'(tbl[i].dc));
      end
      cyc(1'b0, 16'h0000, 1'b0);

      // burst of four: fourth dropped
      for (t = 0; t < 4; t++)
         cyc(1'b1, 16'($urandom), 1'b0);
      chk("burst4 ovf", 32'(oo[0]), 1);
      for (t = 4; t < 30; t++) begin
         cyc(1'b0, 16'h0000, 1'b0);
         chk("burst4 sow", 32'(so[0]), 32'((t + 1) == 9 || (t + 1) == 17));
         chk("burst4 vld", 32'(vo[0]), 32'((t + 1) <= 24));
         chk("burst4 ovf hold", 32'(oo[0]), 1);
      end
      cyc(1'b0, 16'h0000, 1'b1);
      chk("ovf clear", 32'(oo[0]), 0);
      cyc(1'b0, 16'h0000, 1'b0);

      // burst of three plus push coincident with pop at full
      for (t = 0; t < 40; t++) begin
         v = (t < 3) || (t == 8);
         cyc(v, 16'($urandom), 1'b0);
         chk("popush sow", 32'(so[0]),
             32'((t + 1) == 1 || (t + 1) == 9 || (t + 1) == 17 || (t + 1) == 25));
         chk("popush vld", 32'(vo[0]), 32'((t + 1) <= 32));
         chk("popush ovf", 32'(oo[0]), 0);
      end

      // reset in the middle of a word
      cyc(1'b1, 16'h3C5A, 1'b0);
      for (t = 1; t < 4; t++)
         cyc(1'b0, 16'h0000, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1);
      chk("midrst vld", 32'(vo[0]), 0);
      chk("midrst busy", 32'(bo[0]), 0);
      cyc(1'b1, 16'hA5C3, 1'b0);
      chk("midrst sow", 32'(so[0]), 1);
      for (t = 0; t < 10; t++)
         cyc(1'b0, 16'h0000, 1'b0);

      // SER_CYC == NDIG stream, one word every 4 cycles
      cyc(1'b0, 16'h0000, 1'b1);
      for (t = 0; t < 80; t++) begin
         cyc((t % 4) == 0, 16'($urandom), 1'b0);
         chk("stream vld", 32'(vo[3]), 1);
         chk("stream act", 32'(ao[3]), 1);
         chk("stream ovf", 32'(oo[3]), 0);
      end
      for (t = 0; t < 10; t++)
         cyc(1'b0, 16'h0000, 1'b0);

      // randomized traffic
      for (int blk = 0; blk < 8; blk++) begin
         rate = 5 + blk * 8;
         for (t = 0; t < 100; t++) begin
            v = ($urandom_range(0, 99) < rate);
            r = ($urandom_range(0, 299) == 0);
            cyc(v, 16'($urandom), r);
         end
      end
      for (t = 0; t < 40; t++)
         cyc(1'b0, 16'h0000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
